// File: rtl/mem_req_ctrl.sv
// Single-outstanding request controller that sequences a synchronous RAM through setup/access phases.
// Optional write readback verification is compiled in with `define MEM_REQ_CTRL_VERIFY_EN.
module mem_req_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_RW,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_Data,
  output logic              Resp_Valid,
  input  logic              Resp_Ready,
  output logic [DATA_W-1:0] Resp_Data,
  output logic              Resp_Err,
  output logic              Mem_Enable,
  output logic              Mem_RW,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_In,
  input  logic [DATA_W-1:0] Mem_Out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    VSETUP  = 3'd3,
    VACCESS = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t r_state;
  logic   r_rw;

`ifdef MEM_REQ_CTRL_VERIFY_EN
  logic r_resp_err;
  assign Resp_Err = r_resp_err;
`else
  assign Resp_Err = 1'b0;
`endif

  // Mem_Address/Mem_In double as the registered request, so they stay put
  // from SETUP through every enabled cycle of the transaction.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_rw        <= 1'b1;
      Req_Ready   <= 1'b0;
      Resp_Valid  <= 1'b0;
      Resp_Data   <= '0;
      Mem_Enable  <= 1'b0;
      Mem_RW      <= 1'b1;
      Mem_Address <= '0;
      Mem_In      <= '0;
`ifdef MEM_REQ_CTRL_VERIFY_EN
      r_resp_err  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of state and outputs regardless of statement order.
      case (r_state)
        IDLE: begin
          if (Req_Valid && Req_Ready) begin
            r_state     <= SETUP;
            r_rw        <= Req_RW;
            Req_Ready   <= 1'b0;
            Mem_RW      <= Req_RW;
            Mem_Address <= Req_Addr;
            Mem_In      <= Req_Data;
`ifdef MEM_REQ_CTRL_VERIFY_EN
            r_resp_err  <= 1'b0;
`endif
          end else begin
            Req_Ready <= 1'b1;
          end
        end
        SETUP: begin
          r_state    <= ACCESS;
          Mem_Enable <= 1'b1;
        end
        ACCESS: begin
          Mem_Enable <= 1'b0;
          if (r_rw) begin
            Resp_Data  <= Mem_Out;
            Resp_Valid <= 1'b1;
            r_state    <= RESP;
          end else begin
`ifdef MEM_REQ_CTRL_VERIFY_EN
            // Switch to read only now that the enable is low for VSETUP.
            Mem_RW  <= 1'b1;
            r_state <= VSETUP;
`else
            Resp_Data  <= Mem_In;
            Resp_Valid <= 1'b1;
            r_state    <= RESP;
`endif
          end
        end
`ifdef MEM_REQ_CTRL_VERIFY_EN
        VSETUP: begin
          r_state    <= VACCESS;
          Mem_Enable <= 1'b1;
        end
        VACCESS: begin
          Mem_Enable <= 1'b0;
          Resp_Data  <= Mem_In;
          r_resp_err <= (Mem_Out != Mem_In);
          Resp_Valid <= 1'b1;
          r_state    <= RESP;
        end
`endif
        RESP: begin
          if (Resp_Ready) begin
            Resp_Valid <= 1'b0;
            Req_Ready  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          Mem_Enable <= 1'b0;
          Resp_Valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural synchronous RAM and a protocol monitor.
// Define MEM_REQ_CTRL_VERIFY_EN for both bench and RTL to exercise the readback path.
module tb_mem_req_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
`ifdef MEM_REQ_CTRL_VERIFY_EN
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 3;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b1;
  logic              Req_Valid = 1'b0;
  logic              Req_Ready;
  logic              Req_RW = 1'b1;
  logic [ADDR_W-1:0] Req_Addr = '0;
  logic [DATA_W-1:0] Req_Data = '0;
  logic              Resp_Valid;
  logic              Resp_Ready = 1'b0;
  logic [DATA_W-1:0] Resp_Data;
  logic              Resp_Err;
  logic              Mem_Enable;
  logic              Mem_RW;
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_In;
  logic [DATA_W-1:0] Mem_Out;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_resp = 0;
  bit force_zero = 1'b0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  mem_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_RW     (Req_RW),
    .Req_Addr   (Req_Addr),
    .Req_Data   (Req_Data),
    .Resp_Valid (Resp_Valid),
    .Resp_Ready (Resp_Ready),
    .Resp_Data  (Resp_Data),
    .Resp_Err   (Resp_Err),
    .Mem_Enable (Mem_Enable),
    .Mem_RW     (Mem_RW),
    .Mem_Address(Mem_Address),
    .Mem_In     (Mem_In),
    .Mem_Out    (Mem_Out)
  );

  always #5 Clk = ~Clk;

  // Synchronous-write RAM; read data is only meaningful while enabled for read.
  always @(posedge Clk) begin
    if (Mem_Enable && !Mem_RW) ram[Mem_Address] <= Mem_In;
  end
  assign Mem_Out = (Mem_Enable && Mem_RW) ? (force_zero ? '0 : ram[Mem_Address]) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: RAM controls may only change in cycles with the enable low.
  logic              prev_ok = 1'b0;
  logic              prev_en, prev_rw, prev_ready, prev_rv;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_in;
  always @(negedge Clk) begin
    if (Reset_n && prev_ok) begin
      if (Mem_Enable) begin
        check("mon_rw_stable", Mem_RW, prev_rw);
        check("mon_addr_stable", Mem_Address, prev_addr);
        check("mon_in_stable", Mem_In, prev_in);
        check("mon_en_single", prev_en, 1'b0);
      end
      if (prev_ready && !Req_Ready) n_acc++;
      if (Resp_Valid && !prev_rv) n_resp++;
    end
    prev_ok    <= Reset_n;
    prev_en    <= Mem_Enable;
    prev_rw    <= Mem_RW;
    prev_addr  <= Mem_Address;
    prev_in    <= Mem_In;
    prev_ready <= Req_Ready;
    prev_rv    <= Resp_Valid;
  end

  // One complete transaction; lat counts cycles from the accept edge (cycle 0).
  task automatic txn(input logic rw, input logic [15:0] addr, input logic [31:0] data,
                     input bit early, input int hold,
                     output logic [31:0] rdata, output logic rerr, output int lat);
    int guard;
    @(negedge Clk);
    guard = 0;
    while (!Req_Ready && guard < 10) begin
      @(negedge Clk);
      guard++;
    end
    Req_Valid  = 1'b1;
    Req_RW     = rw;
    Req_Addr   = addr;
    Req_Data   = data;
    Resp_Ready = early;
    @(negedge Clk);
    Req_Valid = 1'b0;
    Req_Addr  = ~addr;
    Req_Data  = $urandom;
    lat = 1;
    while (!Resp_Valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    if (!Resp_Valid) lat = -1;
    rdata = Resp_Data;
    rerr  = Resp_Err;
    for (int i = 0; i < hold; i++) begin
      Req_Valid = 1'b1;
      @(negedge Clk);
      check("hold_valid", Resp_Valid, 1'b1);
      check("hold_data", Resp_Data, rdata);
      check("hold_req_ready", Req_Ready, 1'b0);
    end
    Req_Valid  = 1'b0;
    Resp_Ready = 1'b1;
    @(negedge Clk);
    Resp_Ready = 1'b0;
    check("post_resp_ready", Req_Ready, 1'b1);
    check("post_resp_valid", Resp_Valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [15:0] pool [8];
    logic [31:0] model [8];
    int          base_acc, base_resp;

    pool = '{16'h0000, 16'h0001, 16'h0010, 16'h00FF, 16'h1234, 16'h8000, 16'hFFFE, 16'hFFFF};

    // Reset values apply immediately.
    #2 Reset_n = 1'b0;
    #1;
    check("rst_req_ready", Req_Ready, 1'b0);
    check("rst_mem_en", Mem_Enable, 1'b0);
    check("rst_mem_rw", Mem_RW, 1'b1);
    check("rst_mem_addr", Mem_Address, 16'h0000);
    check("rst_mem_in", Mem_In, 32'h0);
    check("rst_resp_valid", Resp_Valid, 1'b0);
    check("rst_resp_data", Resp_Data, 32'h0);
    check("rst_resp_err", Resp_Err, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1 check("rel_req_ready_low", Req_Ready, 1'b0);
    @(negedge Clk);
    check("rel_req_ready_high", Req_Ready, 1'b1);

    // Sentinel at address 0 to detect any wrap from 16'hFFFF.
    txn(1'b0, 16'h0000, 32'h5A5A_5A5A, 1'b0, 0, rd, er, lat);
    check("wr0_lat", lat, WR_LAT);

    txn(1'b0, 16'h0010, 32'hDEAD_BEEF, 1'b0, 0, rd, er, lat);
    check("wr_lat", lat, WR_LAT);
    check("wr_echo", rd, 32'hDEAD_BEEF);
    check("wr_err", er, 1'b0);
    txn(1'b1, 16'h0010, 32'h0, 1'b0, 0, rd, er, lat);
    check("rd_lat", lat, 3);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", er, 1'b0);

    txn(1'b0, 16'hFFFF, 32'hA5A5_0FF0, 1'b0, 0, rd, er, lat);
    check("wr_ffff_echo", rd, 32'hA5A5_0FF0);
    txn(1'b1, 16'hFFFF, 32'h0, 1'b0, 0, rd, er, lat);
    check("rd_ffff_data", rd, 32'hA5A5_0FF0);
    txn(1'b1, 16'h0000, 32'h0, 1'b0, 0, rd, er, lat);
    check("rd_0000_untouched", rd, 32'h5A5A_5A5A);

    txn(1'b1, 16'h0010, 32'h0, 1'b1, 0, rd, er, lat);
    check("early_ready_lat", lat, 3);
    check("early_ready_data", rd, 32'hDEAD_BEEF);

    txn(1'b1, 16'hFFFF, 32'h0, 1'b0, 5, rd, er, lat);
    check("hold_rd_data", rd, 32'hA5A5_0FF0);

    // Reset during the ACCESS cycle of a read aborts it without a response.
    @(negedge Clk);
    Req_Valid = 1'b1;
    Req_RW    = 1'b1;
    Req_Addr  = 16'h0010;
    @(negedge Clk);
    Req_Valid = 1'b0;
    check("abort_setup_en", Mem_Enable, 1'b0);
    check("abort_setup_addr", Mem_Address, 16'h0010);
    @(negedge Clk);
    check("abort_access_en", Mem_Enable, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_mem_en", Mem_Enable, 1'b0);
    check("abort_mem_rw", Mem_RW, 1'b1);
    check("abort_mem_addr", Mem_Address, 16'h0000);
    check("abort_mem_in", Mem_In, 32'h0);
    check("abort_resp_valid", Resp_Valid, 1'b0);
    check("abort_resp_data", Resp_Data, 32'h0);
    check("abort_req_ready", Req_Ready, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("abort_no_resp", Resp_Valid, 1'b0);
    end
    txn(1'b1, 16'h0010, 32'h0, 1'b0, 0, rd, er, lat);
    check("after_abort_lat", lat, 3);
    check("after_abort_data", rd, 32'hDEAD_BEEF);

`ifdef MEM_REQ_CTRL_VERIFY_EN
    force_zero = 1'b1;
    txn(1'b0, 16'h0040, 32'h1234_5678, 1'b0, 0, rd, er, lat);
    force_zero = 1'b0;
    check("verify_forced_err", er, 1'b1);
    check("verify_forced_lat", lat, 5);
    check("verify_forced_echo", rd, 32'h1234_5678);
    txn(1'b0, 16'h0040, 32'h1234_5678, 1'b0, 0, rd, er, lat);
    check("verify_ok_err", er, 1'b0);
    check("verify_ok_lat", lat, 5);
`endif

    // Mixed traffic over a small address pool against a reference copy.
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      txn(1'b0, pool[i], model[i], 1'b0, 0, rd, er, lat);
      check("pool_init_echo", rd, model[i]);
    end
    base_acc  = n_acc;
    base_resp = n_resp;
    for (int n = 0; n < 200; n++) begin
      int          idx;
      logic        rw;
      logic [31:0] wd;
      idx = $urandom_range(0, 7);
      rw  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      txn(rw, pool[idx], wd, 1'($urandom_range(0, 1)), 0, rd, er, lat);
      if (rw) begin
        check("rand_rd_data", rd, model[idx]);
        check("rand_rd_lat", lat, 3);
      end else begin
        model[idx] = wd;
        check("rand_wr_echo", rd, wd);
        check("rand_wr_lat", lat, WR_LAT);
      end
      check("rand_err", er, 1'b0);
    end
    check("rand_accept_count", n_acc - base_acc, 200);
    check("rand_resp_count", n_resp - base_resp, n_acc - base_acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 16, memory address width.
REQ-002 Parameter: DATA_W, default 32, memory data width.
REQ-003 Clk  input  1  single clock, all state on rising edge.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 Req_Valid  input  1  requester presents a transaction.
REQ-006 Req_Ready  output  1  controller accepts a transaction this cycle.
REQ-007 Req_RW  input  1  1 = read, 0 = write.
REQ-008 Req_Addr  input  ADDR_W  transaction word address.
REQ-009 Req_Data  input  DATA_W  write data, ignored for reads.
REQ-010 Resp_Valid  output  1  response available.
REQ-011 Resp_Ready  input  1  requester consumes the response.
REQ-012 Resp_Data  output  DATA_W  read data, or echoed write data for writes.
REQ-013 Resp_Err  output  1  write readback mismatch; constant 0 when the feature is compiled out.
REQ-014 Mem_Enable  output  1  drives the RAM enable.
REQ-015 Mem_RW  output  1  drives RAM RW, 1 = read.
REQ-016 Mem_Address  output  ADDR_W  drives the RAM address.
REQ-017 Mem_In  output  DATA_W  drives the RAM write data.
REQ-018 Mem_Out  input  DATA_W  RAM read data, valid only while Mem_Enable=1 and Mem_RW=1.

Function
REQ-019 The FSM SHALL use states IDLE, SETUP, ACCESS, VSETUP, VACCESS, RESP.
REQ-020 Req_Ready SHALL be 1 only in IDLE; a request is accepted when Req_Valid and Req_Ready are both 1 on a rising edge.
REQ-021 On accept, the block SHALL register Req_RW, Req_Addr and Req_Data and go to SETUP.
REQ-022 SETUP: Mem_Address, Mem_In and Mem_RW are driven from the registered request; Mem_Enable=0. Next state is ACCESS.
REQ-023 ACCESS: Mem_Enable=1 for exactly one cycle. For a read, Mem_Out is captured into Resp_Data at the closing edge.
REQ-024 After ACCESS, a read SHALL go to RESP. A write SHALL go to VSETUP when MEM_REQ_CTRL_VERIFY_EN is defined, else to RESP.
REQ-025 Mem_RW SHALL change only in cycles where Mem_Enable=0, so no spurious RAM write can occur.
REQ-026 Mem_Address and Mem_In SHALL be stable for the whole of every cycle with Mem_Enable=1.
REQ-027 RESP: Resp_Valid=1 and Resp_Data/Resp_Err are held stable until Resp_Valid and Resp_Ready are both 1 on an edge; the state then returns to IDLE.
REQ-028 Latency: accept edge at cycle 0, SETUP in cycle 1, ACCESS in cycle 2, Resp_Valid=1 from cycle 3. A verified write adds 2 cycles.
REQ-029 Throughput: at most one transaction in flight; a new accept is possible on the cycle after the response handshake.
REQ-030 Resp_Ready held high before RESP SHALL have no effect; Req_Valid outside IDLE SHALL be ignored.
REQ-031 For writes, Resp_Data SHALL equal the registered write data.
REQ-032 Address arithmetic: none; Req_Addr is passed through unmodified, including 16'hFFFF.

Reset
REQ-033 Reset_n=0 SHALL immediately force state=IDLE, Mem_Enable=0, Mem_RW=1, Mem_Address=0, Mem_In=0, Resp_Valid=0, Resp_Data=0, Resp_Err=0, Req_Ready=0.
REQ-034 After reset release, Req_Ready SHALL be 1 from the first rising edge onward.
REQ-035 Reset asserted during ACCESS SHALL abort the transaction with no response; RAM contents at that address are undefined.

Configuration
REQ-036 With MEM_REQ_CTRL_VERIFY_EN defined, a write SHALL continue to VSETUP (Mem_Enable=0, Mem_RW=1), then VACCESS (Mem_Enable=1, Mem_RW=1, capture Mem_Out).
REQ-037 In that mode, Resp_Err SHALL be 1 if the captured Mem_Out differs from the write data, and 0 otherwise.
REQ-038 Without MEM_REQ_CTRL_VERIFY_EN, VSETUP and VACCESS SHALL be unreachable, and Resp_Err SHALL be tied to 0.

Verification
REQ-039 Reset, then write 32'hDEADBEEF to 16'h0010, then read 16'h0010 -> read Resp_Data=32'hDEADBEEF, Resp_Valid at cycle 3 after accept.
REQ-040 Write to 16'hFFFF, then read it back -> data matches; no wrap and no write to address 0.
REQ-041 Hold Resp_Ready=0 for 5 cycles in RESP -> Resp_Valid stays 1, Resp_Data stable, Req_Ready=0 throughout.
REQ-042 Assert Reset_n=0 during ACCESS of a read -> all outputs reach reset values within the same cycle; no response is issued; next request completes normally.
REQ-043 Monitor over a random sequence of 200 mixed requests -> Mem_RW never toggles while Mem_Enable=1, and each request yields exactly one response.
REQ-044 With VERIFY_EN defined, write 32'h12345678 with RAM model forced to return 32'h0 -> Resp_Err=1, response at cycle 5; with an unforced model -> Resp_Err=0.
